log_mac_acc: RTL and testbench



---
 rtl/log_mac_acc_pkg.sv | 49 ++++
 rtl/log_mac_acc_c1_add_eac.sv | 30 +++
 rtl/log_mac_acc.sv | 115 +++++++++++
 tb/tb_log_mac_acc.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_mac_acc_pkg.sv
// ============================================================================
// Module      : log_mac_acc_pkg
// Description : Shared one's-complement helpers for the log-arithmetic stages:
//               accumulator width derivation, negative-zero pattern,
//               sign extension and accumulator FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package log_mac_acc_pkg;

  // Widest word any helper below can operate on.
  localparam int C1_MAX_W = 64;

  // Accumulator width: full 2N-bit product plus guard bits.
  function automatic int acc_width(input int n, input int g);
    return 2 * n + g;
  endfunction

  // One's-complement negative zero (all ones) in the low w bits.
  function automatic logic [C1_MAX_W-1:0] c1_neg_zero(input int w);
    logic [C1_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < C1_MAX_W; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

  // One's-complement sign extension: replicate bit from_w-1 upward.
  function automatic logic [C1_MAX_W-1:0] c1_sext(input logic [C1_MAX_W-1:0] v,
                                                  input int from_w);
    logic [C1_MAX_W-1:0] r;
    r = v;
    for (int i = 0; i < C1_MAX_W; i++) begin
      if (i >= from_w) r[i] = v[from_w-1];
    end
    return r;
  endfunction

  // ACCUM: no result pending; HOLD: result presented on out_*.
  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/log_mac_acc_c1_add_eac.sv
// ============================================================================
// Module      : c1_add_eac
// Description : W-bit one's-complement adder with end-around carry and
//               signed-overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module c1_add_eac #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         ovf_o
);

  logic [W:0] raw_sum;

  // First add keeps the carry; the carry is folded back into bit 0. A valid
  // one's-complement sum cannot carry out of the second add.
  always_comb begin
    raw_sum = {1'b0, a_i} + {1'b0, b_i};
    sum_o   = raw_sum[W-1:0] + {{(W-1){1'b0}}, raw_sum[W]};
    ovf_o   = (a_i[W-1] == b_i[W-1]) && (sum_o[W-1] != a_i[W-1]);
  end

endmodule

`default_nettype wire

// File: rtl/log_mac_acc.sv
// ============================================================================
// Module      : log_mac_acc
// Description : Streaming one's-complement dot-product accumulator. Sums
//               2N-bit product beats per vector (closed by in_last) and
//               presents sum, beat count and sticky overflow via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module log_mac_acc
  import log_mac_acc_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int G     = 8,
  parameter  int CNT_W = 16,
  localparam int ACC_W = acc_width(N, G)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;
  logic             oovf_q, oovf_d;

  logic             fire;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;

  assign out_valid = (state_q == ST_HOLD);
  assign in_ready  = ~out_valid | out_ready;
  assign fire      = in_valid & in_ready;
  assign prod_ext  = ACC_W'(c1_sext(C1_MAX_W'(in_prod), 2 * N));
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  assign out_sum   = sum_q;
  assign out_count = ocnt_q;
  assign out_ovf   = oovf_q;

  c1_add_eac #(
    .W (ACC_W)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (prod_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // Next-state: accumulate on fire, close vector on last, release on handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum_d   = sum_q;
    ocnt_d  = ocnt_q;
    oovf_d  = oovf_q;
    if (fire) begin
      acc_d = add_sum;
      cnt_d = cnt_inc;
      ovf_d = ovf_q | add_ovf;
    end
    if (fire && in_last) begin
      // Negative zero is reported as positive zero.
      sum_d   = (add_sum == ACC_W'(c1_neg_zero(ACC_W))) ? '0 : add_sum;
      ocnt_d  = cnt_inc;
      oovf_d  = ovf_q | add_ovf;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ST_HOLD;
    end else if ((state_q == ST_HOLD) && out_ready) begin
      state_d = ST_ACCUM;
    end
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sum_q   <= '0;
      ocnt_q  <= '0;
      oovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sum_q   <= sum_d;
      ocnt_q  <= ocnt_d;
      oovf_q  <= oovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_log_mac_acc.sv
// ============================================================================
// Module      : tb_log_mac_acc
// Description : Scoreboard bench for log_mac_acc with an integer-arithmetic
//               reference model (one's-complement sum = sum mod 2^W-1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_log_mac_acc;

  localparam int     N     = 8;
  localparam int     G     = 8;
  localparam int     CNT_W = 16;
  localparam int     ACC_W = 2 * N + G;
  localparam longint MODV  = (64'sd1 <<< ACC_W) - 64'sd1;
  localparam longint MAXV  = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2*N-1:0]   in_prod = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  log_mac_acc #(.N(N), .G(G), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  longint m_v    = 0;
  int     m_cnt  = 0;
  bit     m_ovf  = 1'b0;
  bit     rdy_force = 1'b1;
  bit     rdy_val   = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value of a 16-bit one's-complement word.
  function automatic longint c1_val(input logic [2*N-1:0] p);
    logic [2*N-1:0] mag;
    mag = ~p;
    if (p[2*N-1]) return -longint'(mag);
    return longint'(p);
  endfunction

  task automatic model_reset();
    m_v   = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Reference: exact integer sum kept within +-MAXV by wrapping mod 2^W-1.
  task automatic model_beat(input logic [2*N-1:0] p, input logic l);
    longint t;
    exp_t   e;
    t = m_v + c1_val(p);
    if (t > MAXV || t < -MAXV) m_ovf = 1'b1;
    if (t > MAXV) t = t - MODV;
    else if (t < -MAXV) t = t + MODV;
    m_v   = t;
    m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    if (l) begin
      e.sum = ACC_W'((m_v < 0) ? (MODV + m_v) : m_v);
      e.cnt = CNT_W'(m_cnt);
      e.ovf = m_ovf;
      sb.push_back(e);
      model_reset();
    end
  endtask

  // Present one beat at a negedge; it fires at the following posedge.
  task automatic send(input logic [2*N-1:0] p, input logic l);
    int w;
    @(negedge clk);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    w = 0;
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      model_beat(p, l);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending results got %0d expected 0", sb.size());
    end
  endtask

  // Consumer ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare on handshake, and check stability while stalled.
  bit               held = 1'b0;
  logic [ACC_W-1:0] h_sum;
  logic [CNT_W-1:0] h_cnt;
  logic             h_ovf;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_sum", 64'(out_sum), 64'(h_sum));
        chk("hold_count", 64'(out_count), 64'(h_cnt));
        chk("hold_ovf", 64'(out_ovf), 64'(h_ovf));
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0h expected none", out_sum);
        end else begin
          e = sb.pop_front();
          chk("sum", 64'(out_sum), 64'(e.sum));
          chk("count", 64'(out_count), 64'(e.cnt));
          chk("ovf", 64'(out_ovf), 64'(e.ovf));
        end
      end else if (out_valid) begin
        held  = 1'b1;
        h_sum = out_sum;
        h_cnt = out_count;
        h_ovf = out_ovf;
      end
    end
  end

  initial begin
    logic [ACC_W-1:0] s_keep;
    int               len;
    logic [2*N-1:0]   p;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(out_sum), 64'(0));
    chk("rst_count", 64'(out_count), 64'(0));
    chk("rst_ovf", 64'(out_ovf), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // +5 + -3, result one cycle after the last fire.
    send(16'h0005, 1'b0);
    send(16'hFFFC, 1'b1);
    idle();
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("lat_sum", 64'(out_sum), 64'h2);
    chk("lat_count", 64'(out_count), 64'(2));
    chk("lat_ovf", 64'(out_ovf), 64'(0));
    drain();

    // Negative zero normalisation.
    send(16'h0005, 1'b0);
    send(16'hFFFA, 1'b1);
    idle();
    chk("negzero_sum", 64'(out_sum), 64'h0);
    drain();

    // Back-to-back single-beat vectors.
    @(negedge clk);
    in_valid = 1'b1; in_prod = 16'h0001; in_last = 1'b1;
    model_beat(16'h0001, 1'b1);
    @(negedge clk);
    chk("b2b_valid0", 64'(out_valid), 64'(1));
    chk("b2b_sum0", 64'(out_sum), 64'h000001);
    in_prod = 16'hFFFE;
    model_beat(16'hFFFE, 1'b1);
    @(negedge clk);
    chk("b2b_valid1", 64'(out_valid), 64'(1));
    chk("b2b_sum1", 64'(out_sum), 64'hFFFFFE);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("b2b_valid2", 64'(out_valid), 64'(0));
    drain();

    // Back-pressure: second vector must wait and lose no beat.
    rdy_val = 1'b0;
    repeat (2) @(negedge clk);
    send(16'h0001, 1'b1);
    idle();
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    s_keep = out_sum;
    fork
      begin
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_sum_stable", 64'(out_sum), 64'(s_keep));
          chk("bp_stall", 64'(in_ready), 64'(0));
        end
        rdy_val = 1'b1;
      end
    join
    idle();
    drain();

    // Overflow boundary: 256 and 257 beats of 0x7FFF, random back-pressure.
    rdy_force = 1'b0;
    for (int i = 0; i < 256; i++) send(16'h7FFF, (i == 255));
    for (int i = 0; i < 257; i++) send(16'h7FFF, (i == 256));
    idle();
    drain();

    // Randomized vectors.
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 1) != 0) p = 16'($urandom);
        else p = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 300))
                                              : ~16'($urandom_range(0, 300));
        send(p, (b == len - 1));
      end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();

    // Reset mid-vector discards the partial sum.
    rdy_force = 1'b1;
    rdy_val   = 1'b1;
    repeat (2) @(negedge clk);
    send(16'h0010, 1'b0);
    send(16'h0010, 1'b0);
    send(16'h0010, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_sum", 64'(out_sum), 64'(0));
    chk("mid_rst_count", 64'(out_count), 64'(0));
    chk("mid_rst_ovf", 64'(out_ovf), 64'(0));
    rst = 1'b0;
    send(16'h0002, 1'b1);
    idle();
    chk("post_rst_sum", 64'(out_sum), 64'h000002);
    chk("post_rst_count", 64'(out_count), 64'(1));
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
